// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit and the data-memory block:
// DMCtrl size/sign codes, FSM state encoding and small decode helpers.
package load_store_unit_pkg;

    typedef enum logic [2:0] {
        DM_B  = 3'b000,
        DM_H  = 3'b001,
        DM_W  = 3'b010,
        DM_BU = 3'b100,
        DM_HU = 3'b101
    } dmctrl_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_RESP  = 2'd3
    } lsu_state_e;

    // Index of the last byte of an access (byte count minus one).
    function automatic logic [1:0] last_idx(input logic [2:0] ctrl);
        case (ctrl[1:0])
            2'b00:   return 2'd0;
            2'b01:   return 2'd1;
            default: return 2'd3;
        endcase
    endfunction

    // Unused codes, and sign-qualified codes on stores, are rejected.
    function automatic logic is_illegal(input logic we, input logic [2:0] ctrl);
        return (ctrl == 3'b011) || (ctrl == 3'b110) || (ctrl == 3'b111) ||
               (we && ctrl[2]);
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Bus bundle between core, load/store unit and byte-wide data memory.
// Signals:
//   req_valid/req_ready/req_we/req_ctrl/req_addr/req_wdata : core request
//   resp_valid/resp_rdata/resp_err                         : completion
//   mem_en/mem_we/mem_addr/mem_wbyte/mem_rbyte             : byte port
// Modports: slave = load/store unit side, master = core + memory side.
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_ctrl;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wbyte;
    logic [7:0]  mem_rbyte;

    modport slave (
        input  req_valid, req_we, req_ctrl, req_addr, req_wdata, mem_rbyte,
        output req_ready, resp_valid, resp_rdata, resp_err,
               mem_en, mem_we, mem_addr, mem_wbyte
    );

    modport master (
        output req_valid, req_we, req_ctrl, req_addr, req_wdata, mem_rbyte,
        input  req_ready, resp_valid, resp_rdata, resp_err,
               mem_en, mem_we, mem_addr, mem_wbyte
    );
endinterface

// File: rtl/load_store_unit_load_extend.sv
// Combinational load-data extension.
// Ports:
//   i_ctrl : DMCtrl code of the load
//   i_raw  : assembled little-endian word (unused upper lanes don't matter)
//   o_data : sign/zero-extended result; W passes through unchanged
module load_extend
    import load_store_unit_pkg::*;
(
    input  logic [2:0]  i_ctrl,
    input  logic [31:0] i_raw,
    output logic [31:0] o_data
);

    always_comb begin
        o_data = i_raw;
        case (i_ctrl)
            DM_B:    o_data = {{24{i_raw[7]}}, i_raw[7:0]};
            DM_H:    o_data = {{16{i_raw[15]}}, i_raw[15:0]};
            DM_BU:   o_data = {24'd0, i_raw[7:0]};
            DM_HU:   o_data = {16'd0, i_raw[15:0]};
            default: o_data = i_raw;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Byte-serial load/store unit: breaks a B/H/W access (any alignment) into
// consecutive byte-port accesses and returns an extended load word.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : load_store_unit_if.slave (core request/response + byte port)
// Parameter MEM_LAT: mem_en to mem_rbyte latency; only 1 is supported.
//
// state | meaning
// IDLE  | req_ready high, waiting for an access
// ISSUE | one byte per cycle on the byte port, load bytes captured a cycle late
// DRAIN | capture the final load byte
// RESP  | one-cycle resp_valid pulse
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int MEM_LAT = 1
) (
    input logic               clk,
    input logic               rst,
    load_store_unit_if.slave  bus
);

    lsu_state_e  r_state;
    lsu_state_e  w_next;
    logic        r_we;
    logic [2:0]  r_ctrl;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_data;
    logic [1:0]  r_last;
    logic [1:0]  r_idx;
    logic        r_err;

    logic        w_illegal;
    logic        w_drain_done;
    logic [1:0]  w_lane_prev;
    logic [31:0] w_ext;

    assign w_illegal    = is_illegal(bus.req_we, bus.req_ctrl);
    assign w_drain_done = (r_idx == 2'(MEM_LAT - 1));
    // Byte read in the previous ISSUE cycle lands in the lane one behind.
    assign w_lane_prev  = r_idx - 2'd1;

    load_extend u_load_extend (
        .i_ctrl (r_ctrl),
        .i_raw  (r_data),
        .o_data (w_ext)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (bus.req_valid) w_next = w_illegal ? ST_RESP : ST_ISSUE;
            ST_ISSUE: if (r_idx == r_last) w_next = r_we ? ST_RESP : ST_DRAIN;
            ST_DRAIN: if (w_drain_done) w_next = ST_RESP;
            ST_RESP:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we    <= 1'b0;
            r_ctrl  <= 3'd0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_data  <= 32'd0;
            r_last  <= 2'd0;
            r_idx   <= 2'd0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        r_we    <= bus.req_we;
                        r_ctrl  <= bus.req_ctrl;
                        r_addr  <= bus.req_addr;
                        r_wdata <= bus.req_wdata;
                        r_data  <= 32'd0;
                        r_last  <= last_idx(bus.req_ctrl);
                        r_idx   <= 2'd0;
                        r_err   <= w_illegal;
                    end
                end
                ST_ISSUE: begin
                    if (!r_we && (r_idx != 2'd0))
                        r_data[{w_lane_prev, 3'b000} +: 8] <= bus.mem_rbyte;
                    // Restart the index so DRAIN can count its own cycles.
                    r_idx <= (r_idx == r_last) ? 2'd0 : r_idx + 2'd1;
                end
                ST_DRAIN: begin
                    r_data[{r_last, 3'b000} +: 8] <= bus.mem_rbyte;
                    r_idx <= r_idx + 2'd1;
                end
                default: ;
            endcase
        end
    end

    // All outputs decode from registered state so reset clears them at once.
    always_comb begin
        bus.req_ready  = (r_state == ST_IDLE);
        bus.resp_valid = (r_state == ST_RESP);
        bus.resp_err   = (r_state == ST_RESP) && r_err;
        bus.resp_rdata = ((r_state == ST_RESP) && !r_err && !r_we) ? w_ext : 32'd0;
        bus.mem_en     = (r_state == ST_ISSUE);
        bus.mem_we     = (r_state == ST_ISSUE) && r_we;
        bus.mem_addr   = (r_state == ST_ISSUE) ? r_addr + {30'd0, r_idx} : 32'd0;
        bus.mem_wbyte  = ((r_state == ST_ISSUE) && r_we) ?
                         r_wdata[{r_idx, 3'b000} +: 8] : 8'd0;
    end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    load_store_unit_if bus();

    load_store_unit #(.MEM_LAT(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Byte memory with one-cycle read latency, indexed by the low address byte.
    logic [7:0] mem [256];
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) mem[bus.mem_addr[7:0]] <= bus.mem_wbyte;
            else            bus.mem_rbyte <= mem[bus.mem_addr[7:0]];
        end
    end

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc;
        int          lat;
    } resp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [7:0]  wbyte;
    } macc_t;

    resp_t exp_resp[$];
    macc_t exp_mem[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_mem(input logic we, input logic [31:0] addr, input logic [7:0] wbyte);
        exp_mem.push_back('{we: we, addr: addr, wbyte: wbyte});
    endtask

    // exp_lat of 0 means the access will be aborted and produces no response.
    task automatic issue(input logic we, input logic [2:0] ctrl, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_rdata,
                         input logic exp_err, input int exp_lat);
        int waited;
        waited = 0;
        @(negedge clk);
        while (!bus.req_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.req_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL ready_timeout: req_ready still 0 after %0d cycles", waited);
            return;
        end
        bus.req_we    = we;
        bus.req_ctrl  = ctrl;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        if (exp_lat != 0)
            exp_resp.push_back('{rdata: exp_rdata, err: exp_err, acc: cyc, lat: exp_lat});
    endtask

    // Monitor: compares byte-port activity and responses against the queues.
    initial begin
        resp_t r;
        macc_t m;
        forever begin
            @(negedge clk);
            if (!rst && bus.mem_en) begin
                if (exp_mem.size() == 0) begin
                    check("unexpected_mem_en_addr", bus.mem_addr, 32'hxxxx_xxxx);
                end else begin
                    m = exp_mem.pop_front();
                    check("mem_addr", bus.mem_addr, m.addr);
                    check("mem_we", {31'd0, bus.mem_we}, {31'd0, m.we});
                    if (m.we) check("mem_wbyte", {24'd0, bus.mem_wbyte}, {24'd0, m.wbyte});
                end
            end
            if (!rst && bus.resp_valid) begin
                if (exp_resp.size() == 0) begin
                    check("unexpected_resp_valid", bus.resp_rdata, 32'hxxxx_xxxx);
                end else begin
                    r = exp_resp.pop_front();
                    check("resp_rdata", bus.resp_rdata, r.rdata);
                    check("resp_err", {31'd0, bus.resp_err}, {31'd0, r.err});
                    check("resp_latency", 32'(cyc - r.acc + 1), 32'(r.lat));
                end
            end
        end
    end

    initial begin
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_ctrl  = 3'd0;
        bus.req_addr  = 32'd0;
        bus.req_wdata = 32'd0;
        for (int i = 0; i < 256; i++) mem[i] <= 8'd0;
        mem[8'h80] <= 8'h80;
        mem[8'h13] <= 8'h34;
        mem[8'h14] <= 8'h92;
        mem[8'hFE] <= 8'h11;
        mem[8'hFF] <= 8'h22;
        mem[8'h00] <= 8'h33;
        mem[8'h01] <= 8'h44;

        #3;
        check("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
        check("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        check("rst_resp_rdata", bus.resp_rdata, 32'd0);
        check("rst_resp_err", {31'd0, bus.resp_err}, 32'd0);
        check("rst_mem_en", {31'd0, bus.mem_en}, 32'd0);
        check("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
        check("rst_mem_addr", bus.mem_addr, 32'd0);
        check("rst_mem_wbyte", {24'd0, bus.mem_wbyte}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Misaligned H load before the W store overwrites byte 0x13.
        push_mem(0, 32'h13, 0); push_mem(0, 32'h14, 0);
        issue(0, 3'b001, 32'h13, 0, 32'hFFFF9234, 0, 4);

        push_mem(1, 32'h10, 8'hEF); push_mem(1, 32'h11, 8'hBE);
        push_mem(1, 32'h12, 8'hAD); push_mem(1, 32'h13, 8'hDE);
        issue(1, 3'b010, 32'h10, 32'hDEADBEEF, 32'd0, 0, 5);

        push_mem(0, 32'h10, 0); push_mem(0, 32'h11, 0);
        push_mem(0, 32'h12, 0); push_mem(0, 32'h13, 0);
        issue(0, 3'b010, 32'h10, 0, 32'hDEADBEEF, 0, 6);

        push_mem(0, 32'h80, 0);
        issue(0, 3'b000, 32'h80, 0, 32'hFFFFFF80, 0, 3);
        push_mem(0, 32'h80, 0);
        issue(0, 3'b100, 32'h80, 0, 32'h00000080, 0, 3);

        push_mem(0, 32'hFFFFFFFE, 0); push_mem(0, 32'hFFFFFFFF, 0);
        push_mem(0, 32'h00000000, 0); push_mem(0, 32'h00000001, 0);
        issue(0, 3'b010, 32'hFFFFFFFE, 0, 32'h44332211, 0, 6);

        issue(1, 3'b100, 32'h10, 32'h12345678, 32'd0, 1, 1);
        issue(0, 3'b011, 32'h10, 0, 32'd0, 1, 1);
        issue(0, 3'b111, 32'h10, 0, 32'd0, 1, 1);
        issue(1, 3'b110, 32'h10, 32'h1, 32'd0, 1, 1);

        push_mem(0, 32'h13, 0); push_mem(0, 32'h14, 0);
        issue(0, 3'b101, 32'h13, 0, 32'h000092DE, 0, 4);

        push_mem(1, 32'h20, 8'h78);
        issue(1, 3'b000, 32'h20, 32'h12345678, 32'd0, 0, 2);
        push_mem(0, 32'h20, 0);
        issue(0, 3'b000, 32'h20, 0, 32'h00000078, 0, 3);

        push_mem(1, 32'h21, 8'h01); push_mem(1, 32'h22, 8'h80);
        issue(1, 3'b001, 32'h21, 32'hAAAA8001, 32'd0, 0, 3);
        push_mem(0, 32'h21, 0); push_mem(0, 32'h22, 0);
        issue(0, 3'b001, 32'h21, 0, 32'hFFFF8001, 0, 4);

        // Reset during the second ISSUE cycle of a W load.
        push_mem(0, 32'h40, 0);
        issue(0, 3'b010, 32'h40, 0, 32'd0, 0, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort_mem_en", {31'd0, bus.mem_en}, 32'd0);
        check("abort_req_ready", {31'd0, bus.req_ready}, 32'd1);
        check("abort_mem_addr", bus.mem_addr, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        push_mem(0, 32'h10, 0); push_mem(0, 32'h11, 0);
        push_mem(0, 32'h12, 0); push_mem(0, 32'h13, 0);
        issue(0, 3'b010, 32'h10, 0, 32'hDEADBEEF, 0, 6);

        for (int i = 0; i < 100 && (exp_resp.size() != 0 || exp_mem.size() != 0); i++)
            @(negedge clk);
        repeat (3) @(negedge clk);
        n_cmp++;
        if (exp_resp.size() != 0 || exp_mem.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d responses and %0d byte accesses never seen",
                     exp_resp.size(), exp_mem.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
